// File: rtl/vx_rop_blend_multadd.sv
// ROP blend equation: per-channel src*Fsrc (op) dst*Fdst in 8-bit unorm,
// 3-stage elastic pipeline (multiply, normalize, combine) with a sideband tag.

module vx_rop_blend_multadd_lane (
  input  logic       clk,
  input  logic [3:1] en_i,
  input  logic [2:0] mode_i,
  input  logic [7:0] src_i,
  input  logic [7:0] dst_i,
  input  logic [7:0] fsrc_i,
  input  logic [7:0] fdst_i,
  output logic [7:0] res_o
);
  // round(p/255) without a divider; exact over the full 8x8 product range
  function automatic logic [7:0] norm(input logic [15:0] p);
    logic [15:0] t, u;
    t = p + 16'd128;
    u = t + {8'd0, t[15:8]};
    return 8'(u >> 8);
  endfunction

  logic [15:0] ps_q, pd_q;
  logic [7:0]  s1_q, d1_q, ns_q, nd_q, s2_q, d2_q, res_q, res_d;
  logic [2:0]  m1_q, m2_q;
  logic [8:0]  sum, diff, rdiff;

  always_ff @(posedge clk) begin
    if (en_i[1]) begin
      ps_q <= src_i * fsrc_i;
      pd_q <= dst_i * fdst_i;
      s1_q <= src_i;
      d1_q <= dst_i;
      m1_q <= mode_i;
    end
    if (en_i[2]) begin
      ns_q <= norm(ps_q);
      nd_q <= norm(pd_q);
      s2_q <= s1_q;
      d2_q <= d1_q;
      m2_q <= m1_q;
    end
    if (en_i[3]) res_q <= res_d;
  end

  always_comb begin
    sum   = {1'b0, ns_q} + {1'b0, nd_q};
    diff  = {1'b0, ns_q} - {1'b0, nd_q};
    rdiff = {1'b0, nd_q} - {1'b0, ns_q};
    res_d = sum[8] ? 8'hFF : sum[7:0];
    case (m2_q)
      3'd1:    res_d = diff[8]  ? 8'h00 : diff[7:0];
      3'd2:    res_d = rdiff[8] ? 8'h00 : rdiff[7:0];
      3'd3:    res_d = (s2_q < d2_q) ? s2_q : d2_q;
      3'd4:    res_d = (s2_q > d2_q) ? s2_q : d2_q;
      default: ;
    endcase
  end

  assign res_o = res_q;
endmodule

module vx_rop_blend_multadd #(
  parameter int TAG_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [2:0]           mode_rgb,
  input  logic [2:0]           mode_a,
  input  logic [31:0]          src_color,
  input  logic [31:0]          dst_color,
  input  logic [31:0]          factor_src,
  input  logic [31:0]          factor_dst,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [31:0]          color_out,
  output logic [TAG_WIDTH-1:0] tag_out
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  logic [3:1]                         vld_q, vld_d, ld, en;
  logic [3:1][TAG_WIDTH-1:0]          tag_q;
  logic [NUM_LANES-1:0][VEC_W-1:0]    res;

  // Ready ripples back combinationally so a full pipe still streams 1/cycle
  always_comb begin
    ld[3] = !vld_q[3] || ready_out;
    ld[2] = !vld_q[2] || ld[3];
    ld[1] = !vld_q[1] || ld[2];
    en[1] = ld[1] && valid_in;
    en[2] = ld[2] && vld_q[1];
    en[3] = ld[3] && vld_q[2];
    vld_d[1] = ld[1] ? valid_in : vld_q[1];
    vld_d[2] = ld[2] ? vld_q[1] : vld_q[2];
    vld_d[3] = ld[3] ? vld_q[2] : vld_q[3];
  end

  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (en[1]) tag_q[1] <= tag_in;
    if (en[2]) tag_q[2] <= tag_q[1];
    if (en[3]) tag_q[3] <= tag_q[2];
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vx_rop_blend_multadd_lane u_lane (
      .clk    (clk),
      .en_i   (en),
      .mode_i ((l == NUM_LANES-1) ? mode_a : mode_rgb),
      .src_i  (src_color[l*VEC_W +: VEC_W]),
      .dst_i  (dst_color[l*VEC_W +: VEC_W]),
      .fsrc_i (factor_src[l*VEC_W +: VEC_W]),
      .fdst_i (factor_dst[l*VEC_W +: VEC_W]),
      .res_o  (res[l])
    );
  end

  assign ready_in  = ld[1];
  assign valid_out = vld_q[3];
  assign color_out = vld_q[3] ? res : 32'd0;
  assign tag_out   = vld_q[3] ? tag_q[3] : '0;
endmodule

// File: tb/tb_vx_rop_blend_multadd.sv
// Directed vectors, exhaustive rounding sweep, backpressure and mid-flight reset.
module tb_vx_rop_blend_multadd;
  localparam int TW = 4;

  logic clk = 0, reset = 1, valid_in = 0, ready_out = 1;
  logic ready_in, valid_out;
  logic [2:0] mode_rgb = 0, mode_a = 0;
  logic [31:0] src_color = 0, dst_color = 0, factor_src = 0, factor_dst = 0, color_out;
  logic [TW-1:0] tag_in = 0, tag_out;

  vx_rop_blend_multadd #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .mode_rgb(mode_rgb), .mode_a(mode_a), .src_color(src_color), .dst_color(dst_color),
    .factor_src(factor_src), .factor_dst(factor_dst), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .color_out(color_out), .tag_out(tag_out));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mrgb, ma;
    logic [31:0] src, dst, fs, fd;
    logic [TW-1:0] tag;
    logic [31:0] exp;
  } vec_t;
  typedef struct { logic [31:0] color; logic [TW-1:0] tag; int pres; } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, inflight = 0, ro_mode = 0;
  bit chk_lat = 0, prev_stall = 0;
  logic [31:0] prev_color;
  logic [TW-1:0] prev_tag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ready_out: 0 = always 1, 1 = pattern 1-0-0-1, 2 = always 0
  initial forever begin
    @(posedge clk); #1;
    case (ro_mode)
      1:       ready_out = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       ready_out = 0;
      default: ready_out = 1;
    endcase
  end

  // Monitor: scoreboard, latency, ready_in occupancy rule, stall stability
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete(); inflight = 0; prev_stall = 0;
    end else begin
      chk("ready_in", 32'(ready_in), 32'(!(inflight == 3 && !ready_out)));
      if (prev_stall) begin
        chk("stall_color", color_out, prev_color);
        chk("stall_tag", 32'(tag_out), 32'(prev_tag));
      end
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(valid_out), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("color", color_out, e.color);
          chk("tag", 32'(tag_out), 32'(e.tag));
          if (chk_lat) chk("latency", 32'(cyc - e.pres), 32'd3);
        end
      end
      inflight += int'(valid_in && ready_in) - int'(valid_out && ready_out);
      prev_stall = valid_out && !ready_out;
      prev_color = color_out;
      prev_tag = tag_out;
    end
  end

  task automatic send(input vec_t v);
    int n = 0;
    mode_rgb = v.mrgb; mode_a = v.ma; src_color = v.src; dst_color = v.dst;
    factor_src = v.fs; factor_dst = v.fd; tag_in = v.tag; valid_in = 1;
    forever begin
      @(negedge clk);
      if (ready_in) break;
      if (++n > 200) begin chk("accept_timeout", 32'(ready_in), 32'd1); break; end
    end
    exp_q.push_back('{color: v.exp, tag: v.tag, pres: cyc});
    @(posedge clk); #1;
    valid_in = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t tbl[10];
  vec_t v;
  int t0, seen;

  initial begin
    tbl[0] = '{3'd0, 3'd0, 32'hFF808040, 32'h0,        32'hFFFFFFFF, 32'h0,        4'h5, 32'hFF808040};
    tbl[1] = '{3'd0, 3'd0, 32'h80808080, 32'h80808080, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hA, 32'hFFFFFFFF};
    tbl[2] = '{3'd1, 3'd1, 32'h10101010, 32'h40404040, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h3, 32'h00000000};
    tbl[3] = '{3'd3, 3'd4, 32'h20304050, 32'h10604090, 32'h0,        32'h0,        4'hC, 32'h20304050};
    tbl[4] = '{3'd0, 3'd0, 32'h00FF01FF, 32'h0,        32'h00FF0180, 32'h0,        4'h9, 32'h00FF0080};
    tbl[5] = '{3'd2, 3'd2, 32'h10101010, 32'h40404040, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h1, 32'h30303030};
    tbl[6] = '{3'd5, 3'd7, 32'h20202020, 32'h30303030, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 32'h50505050};
    tbl[7] = '{3'd4, 3'd1, 32'h11223344, 32'h44332211, 32'hFFFFFFFF, 32'h80808080, 4'h6, 32'h00333344};
    tbl[8] = '{3'd1, 3'd1, 32'hC0C0C0C0, 32'h40404040, 32'hFFFFFFFF, 32'h80808080, 4'h2, 32'hA0A0A0A0};
    tbl[9] = '{3'd0, 3'd0, 32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080, 4'h7, 32'h80808080};

    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_color_out", color_out, 32'd0);
    chk("rst_tag_out", 32'(tag_out), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    @(posedge clk); #1;

    chk_lat = 1;
    for (int i = 0; i < 10; i++) begin send(tbl[i]); drain(); end

    // Exhaustive rounding: four a*b pairs per pixel, one pixel per cycle
    chk_lat = 0;
    t0 = cyc;
    for (int i = 0; i < 16384; i++) begin
      v = '{3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, TW'(i), 32'h0};
      for (int c = 0; c < 4; c++) begin
        int p, a, b;
        p = 4 * i + c; a = p >> 8; b = p & 255;
        v.src[c*8 +: 8] = 8'(a);
        v.fs[c*8 +: 8]  = 8'(b);
        v.exp[c*8 +: 8] = 8'((2 * a * b + 255) / 510);
      end
      send(v);
    end
    chk("full_rate_cycles", 32'(cyc - t0), 32'd16384);
    drain();

    // Backpressure with ready_out 1-0-0-1
    ro_mode = 1;
    for (int i = 0; i < 10; i++) begin
      v.mrgb = 0; v.ma = 0; v.src = $urandom; v.dst = 0; v.fs = 32'hFFFFFFFF; v.fd = 0;
      v.tag = TW'($urandom_range(0, 15)); v.exp = v.src;
      send(v);
    end
    drain();

    // Reset with three pixels held
    ro_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      v = '{3'd0, 3'd0, 32'hDEAD0000 + 32'(i), 32'h0, 32'hFFFFFFFF, 32'h0, 4'hE, 32'hDEAD0000 + 32'(i)};
      send(v);
    end
    @(negedge clk);
    chk("full_ready_in", 32'(ready_in), 32'd0);
    chk("full_valid_out", 32'(valid_out), 32'd1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0; ro_mode = 0; ready_out = 1;
    @(negedge clk);
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_color_out", color_out, 32'd0);
    chk("midrst_ready_in", 32'(ready_in), 32'd1);
    seen = 0;
    repeat (6) begin @(negedge clk); if (valid_out) seen++; end
    chk("stale_after_reset", 32'(seen), 32'd0);
    @(posedge clk); #1;
    chk_lat = 1;
    send('{3'd0, 3'd0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h0, 4'hB, 32'h12345678});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
